multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I datapath. It replaces the single-cycle opcode decoder when the datapath shares one memory port between instruction fetch and load/store.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives datapath mux selects and write strobes.
- Runs a req/ready handshake with the shared memory.
- Traps on unsupported opcodes or memory timeout.

Parameters:
TIMEOUT, 16, max cycles mem_req may stay high without mem_ready; 0 disables timeout.
CNT_W, 32, width of the optional performance counters.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
opcode  in  7  instruction[6:0] from IR; stable from DECODE until next FETCH
mem_ready  in  1  memory accepted/completed current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write request (stores only)
iord  out  1  memory address select: 0=PC, 1=ALUOut
ir_write  out  1  load IR
pc_write  out  1  unconditional PC write
pcsrc  out  1  PC source: 0=ALU result, 1=ALUOut register
branch  out  1  conditional PC write; datapath qualifies with zero
alusrc_a  out  2  00=PC, 01=rs1
alusrc_b  out  2  00=rs2, 01=const 4, 10=imm
aluop  out  2  00=add, 01=branch compare, 10=R-type funct, 11=I-type funct
regwrite  out  1  register file write
memtoreg  out  1  WB data: 1=MDR, 0=ALUOut
getpcplus4  out  1  WB data = PC (already PC+4), overrides memtoreg
instr_done  out  1  one-cycle pulse when an instruction retires
err  out  1  sticky trap flag
state_o  out  3  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Reset:
  - rst=0 asynchronously sets state=FETCH, op_q=0, timeout counter=0, err=0.
  - While rst=0, all strobe outputs (mem_req, mem_we, ir_write, pc_write, branch, regwrite, instr_done) are forced to 0 and all selects to 0.
  - Reset asserted mid-instruction abandons it; no strobe is issued.
- Outputs are combinational from state, op_q and mem_ready. Unlisted outputs are 0.
- FETCH:
  - mem_req=1, iord=0, alusrc_a=00, alusrc_b=01, aluop=00.
  - In the cycle mem_ready=1: ir_write=1, pc_write=1, pcsrc=0, next=DECODE. Otherwise stay.
- DECODE:
  - alusrc_a=00, alusrc_b=10, aluop=00; branch/JAL target goes into ALUOut.
  - Latch op_q=opcode[6:2].
  - opcode[1:0]!=11, or op not in {LOAD 00000, IMMOP 00100, STORE 01000, REG 01100, BRANCH 11000, JAL 11011}: next=TRAP.
  - JALR, LUI and AUIPC trap.
- EXEC, by op_q:
  - REG: a=01, b=00, aluop=10; next WB.
  - IMMOP: a=01, b=10, aluop=11; next WB.
  - LOAD/STORE: a=01, b=10, aluop=00; next MEM.
  - BRANCH: a=01, b=00, aluop=01, branch=1, pcsrc=1, instr_done=1; next FETCH.
  - JAL: pc_write=1, pcsrc=1, regwrite=1, getpcplus4=1, instr_done=1; next FETCH.
- MEM:
  - mem_req=1, iord=1, mem_we=(op_q==STORE).
  - On mem_ready: STORE sets instr_done=1 and goes to FETCH; LOAD goes to WB.
- WB: regwrite=1, memtoreg=(op_q==LOAD), instr_done=1; next FETCH.
- Timeout:
  - Counter clears on entry to FETCH or MEM and on mem_ready.
  - It increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0: next=TRAP.
  - A mem_ready arriving in the same cycle wins over timeout.
- TRAP: err=1, all strobes 0; held until reset. mem_ready is ignored.
- A mem_ready outside FETCH/MEM is ignored.
- Latency with zero-wait memory (mem_ready high in the request cycle):
  - REG/IMMOP: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH/JAL: 3 cycles.

Optional Feature:
RV_PERF_CNT_EN. When defined:
- Adds outputs cycle_cnt[CNT_W-1:0] and instret_cnt[CNT_W-1:0], both reset to 0.
- cycle_cnt increments every clock outside reset.
- instret_cnt increments on instr_done.
- Both wrap modulo 2^CNT_W and freeze in TRAP.

When undefined, neither the ports nor the counters exist.

Test Plan:
- R-type add (opcode 0110011), mem_ready tied 1 -> state sequence 0,1,2,4,0; regwrite=1 only in WB; instr_done pulses once, 4 cycles after reset release.
- Load (0000011) with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles with iord=1, mem_we=0; WB has memtoreg=1; total 8 cycles.
- Store (0100011) -> MEM has mem_we=1; no WB state; instr_done pulses in the MEM ready cycle.
- JAL (1101111) -> EXEC has pc_write=1, pcsrc=1, regwrite=1, getpcplus4=1; returns to FETCH after 3 cycles.
- Opcode 0110111 (LUI), then separately mem_ready held 0 with TIMEOUT=16 -> TRAP (state_o=7, err=1) after DECODE, respectively after 17 FETCH cycles; stays in TRAP until rst pulsed low.
- rst pulled low mid-MEM of a store -> immediately mem_req=0, mem_we=0, err=0, state_o=0; with RV_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath sharing one memory port.
// Latency: zero-wait memory gives 3 (BRANCH/JAL), 4 (REG/IMMOP/STORE) or 5 (LOAD) cycles per instruction.
// Backpressure: mem_req held until mem_ready; TIMEOUT stalled cycles trap. Optional counters: RV_PERF_CNT_EN.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
`ifdef RV_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pcsrc,
  output logic             branch,
  output logic [1:0]       alusrc_a,
  output logic [1:0]       alusrc_b,
  output logic [1:0]       aluop,
  output logic             regwrite,
  output logic             memtoreg,
  output logic             getpcplus4,
  output logic             instr_done,
  output logic             err,
`ifdef RV_PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
`endif
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMMOP  = 5'b00100;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  // Counter only needs to reach TIMEOUT; it saturates there.
  localparam int          TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

  state_t        state;
  state_t        state_nx;
  logic [4:0]    op_q;
  logic [TW-1:0] tcnt;
  logic          req_phase;
  logic          tmo;
  logic          op_ok;

  assign req_phase = (state == S_FETCH) || (state == S_MEM);
  assign tmo       = (TIMEOUT != 0) && req_phase && !mem_ready && (tcnt == TLIM);
  assign op_ok     = (opcode[1:0] == 2'b11) &&
                     (opcode[6:2] inside {OP_LOAD, OP_IMMOP, OP_STORE, OP_REG, OP_BRANCH, OP_JAL});
  assign state_o   = state;

  // Next-state selection; a mem_ready in the timeout cycle takes priority over the trap.
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (mem_ready) state_nx = S_DECODE;
                else if (tmo)  state_nx = S_TRAP;
      S_DECODE: state_nx = op_ok ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (op_q)
          OP_REG, OP_IMMOP:  state_nx = S_WB;
          OP_LOAD, OP_STORE: state_nx = S_MEM;
          default:           state_nx = S_FETCH;
        endcase
      end
      S_MEM:    if (mem_ready) state_nx = (op_q == OP_STORE) ? S_FETCH : S_WB;
                else if (tmo)  state_nx = S_TRAP;
      S_WB:     state_nx = S_FETCH;
      default:  state_nx = S_TRAP;
    endcase
  end

  // State, latched opcode class and memory-stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      op_q  <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) op_q <= opcode[6:2];
      if ((state_nx != state) && ((state_nx == S_FETCH) || (state_nx == S_MEM)))
        tcnt <= '0;
      else if (req_phase && mem_ready)
        tcnt <= '0;
      else if (req_phase && (tcnt != TLIM))
        tcnt <= tcnt + 1'b1;
    end
  end

  // Datapath controls decoded from state/op_q; everything forced low while reset is held.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pcsrc      = 1'b0;
    branch     = 1'b0;
    alusrc_a   = 2'b00;
    alusrc_b   = 2'b00;
    aluop      = 2'b00;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    getpcplus4 = 1'b0;
    instr_done = 1'b0;
    err        = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          alusrc_b = 2'b01;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: alusrc_b = 2'b10;
        S_EXEC: begin
          case (op_q)
            OP_REG:    begin alusrc_a = 2'b01; aluop = 2'b10; end
            OP_IMMOP:  begin alusrc_a = 2'b01; alusrc_b = 2'b10; aluop = 2'b11; end
            OP_LOAD,
            OP_STORE:  begin alusrc_a = 2'b01; alusrc_b = 2'b10; end
            OP_BRANCH: begin
              alusrc_a = 2'b01; aluop = 2'b01;
              branch = 1'b1; pcsrc = 1'b1; instr_done = 1'b1;
            end
            OP_JAL: begin
              pc_write = 1'b1; pcsrc = 1'b1; regwrite = 1'b1;
              getpcplus4 = 1'b1; instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req    = 1'b1;
          iord       = 1'b1;
          mem_we     = (op_q == OP_STORE);
          instr_done = mem_ready && (op_q == OP_STORE);
        end
        S_WB: begin
          regwrite   = 1'b1;
          memtoreg   = (op_q == OP_LOAD);
          instr_done = 1'b1;
        end
        S_TRAP:  err = 1'b1;
        default: err = 1'b1;
      endcase
    end
  end

`ifdef RV_PERF_CNT_EN
  // Free-running cycle and retire counters, frozen once trapped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (state != S_TRAP) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (instr_done) instret_cnt <= instret_cnt + 1'b1;
    end
  end
`endif

endmodule
